// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - PCPU pipeline hazard/sequencing controller (stall, flush, freeze)
// Optional event counters (stall_cnt/flush_cnt) enabled by defining PCPU_STALL_CNT_EN.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES    = 2,
   parameter int LU_STALL_CYCLES = 1,
   parameter int CNT_W           = 3
) (
`ifdef PCPU_STALL_CNT_EN
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt,
`endif
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_MemRead,
   input  logic [4:0] ex_rt,
   input  logic       Brch,
   input  logic       Jmp,
   input  logic       imem_ready,
   input  logic       dmem_stall,
   output logic       PCWrite,
   output logic       IF_IDWrite,
   output logic       IF_Flush,
   output logic       ID_EX_Flush,
   output logic       EX_MEM_Write
);

   typedef enum logic [1:0] {RUN, FLUSH, LUSTALL, MWAIT} state_t;

   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 2);
   localparam logic [CNT_W-1:0] LU_LOAD    = CNT_W'(LU_STALL_CYCLES - 2);

   state_t           state_q, state_d;
   state_t           resume_q, resume_d;
   state_t           eff_state;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use;

   assign load_use = ex_MemRead && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   // Once the freeze lifts, MWAIT behaves exactly like the state it interrupted.
   assign eff_state = (state_q == MWAIT) ? resume_q : state_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= RUN;
         resume_q <= RUN;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         resume_q <= resume_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = eff_state;
      resume_d = resume_q;
      cnt_d    = cnt_q;
      if (dmem_stall) begin
         state_d  = MWAIT;
         resume_d = eff_state;
      end else begin
         case (eff_state)
            FLUSH, LUSTALL: begin
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
               if (Brch) begin
                  if (FLUSH_CYCLES > 1) begin
                     state_d = FLUSH;
                     cnt_d   = FLUSH_LOAD;
                  end
               end else if (load_use) begin
                  if (LU_STALL_CYCLES > 1) begin
                     state_d = LUSTALL;
                     cnt_d   = LU_LOAD;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      PCWrite      = 1'b1;
      IF_IDWrite   = 1'b1;
      EX_MEM_Write = 1'b1;
      IF_Flush     = 1'b0;
      ID_EX_Flush  = 1'b0;
      if (!rst) begin
         PCWrite      = 1'b0;
         IF_IDWrite   = 1'b0;
         EX_MEM_Write = 1'b0;
         IF_Flush     = 1'b1;
         ID_EX_Flush  = 1'b1;
      end else if (dmem_stall) begin
         PCWrite      = 1'b0;
         IF_IDWrite   = 1'b0;
         EX_MEM_Write = 1'b0;
      end else begin
         case (eff_state)
            FLUSH: begin
               IF_Flush    = 1'b1;
               ID_EX_Flush = 1'b1;
            end
            LUSTALL: begin
               PCWrite     = 1'b0;
               IF_IDWrite  = 1'b0;
               ID_EX_Flush = 1'b1;
            end
            default: begin
               if (Brch) begin
                  IF_Flush    = 1'b1;
                  ID_EX_Flush = 1'b1;
               end else if (load_use) begin
                  PCWrite     = 1'b0;
                  IF_IDWrite  = 1'b0;
                  ID_EX_Flush = 1'b1;
               end else if (Jmp) begin
                  IF_Flush = 1'b1;
               end else if (!imem_ready) begin
                  PCWrite  = 1'b0;
                  IF_Flush = 1'b1;
               end
            end
         endcase
      end
   end

`ifdef PCPU_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!rst) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (!PCWrite) stall_cnt_d = stall_cnt_q + 32'd1;
         if (IF_Flush) flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
